// File: rtl/prescaler_ctrl_if.sv
// Configuration port of the prescaler tick scheduler: valid/ready transfer of
// a period (ticks every period+1 cycles) and a burst length (0 = continuous).
interface prescaler_ctrl_if #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
);
    logic               cfg_valid_i;
    logic               cfg_ready_o;
    logic [CNT_W-1:0]   cfg_period_i;
    logic [BURST_W-1:0] cfg_count_i;

    modport master (
        output cfg_valid_i,
        output cfg_period_i,
        output cfg_count_i,
        input  cfg_ready_o
    );

    modport slave (
        input  cfg_valid_i,
        input  cfg_period_i,
        input  cfg_count_i,
        output cfg_ready_o
    );
endinterface

// File: rtl/prescaler_ctrl.sv
// Programmable tick scheduler: single-cycle ticks every period+1 cycles,
// continuous or N-tick burst, with period changes deferred to tick boundaries.
//
// state | meaning
// IDLE  | no run; config words load period_q/count_q directly
// RUN   | counting; config words wait in the pending register until a tick
module prescaler_ctrl #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    prescaler_ctrl_if.slave    cfg,
    input  logic               start_i,
    input  logic               stop_i,
    output logic               tick_o,
    output logic               done_o,
    output logic               busy_o,
    output logic [BURST_W-1:0] tick_cnt_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [BURST_W-1:0] count_q, count_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tick_q, tick_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [BURST_W-1:0] tick_cnt_q, tick_cnt_d;
    logic               pend_q, pend_d;
    logic [CNT_W-1:0]   pend_period_q, pend_period_d;
    logic [BURST_W-1:0] pend_count_q, pend_count_d;

    logic               cfg_acc;
    logic               tick_now;
    logic               leave;
    logic [BURST_W-1:0] tick_cnt_inc;

    assign cfg.cfg_ready_o = ~pend_q;

    always_comb begin
        state_d       = state_q;
        period_d      = period_q;
        count_d       = count_q;
        cnt_d         = cnt_q;
        tick_d        = 1'b0;
        done_d        = 1'b0;
        busy_d        = busy_q;
        tick_cnt_d    = tick_cnt_q;
        pend_d        = pend_q;
        pend_period_d = pend_period_q;
        pend_count_d  = pend_count_q;
        leave         = 1'b0;
        cfg_acc       = cfg.cfg_valid_i & ~pend_q;
        tick_now      = (cnt_q == period_q);
        tick_cnt_inc  = tick_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (cfg_acc) begin
                    period_d = cfg.cfg_period_i;
                    count_d  = cfg.cfg_count_i;
                end
                if (start_i) begin
                    state_d    = RUN;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    tick_cnt_d = '0;
                end
            end
            RUN: begin
                if (tick_now) begin
                    cnt_d      = '0;
                    tick_d     = 1'b1;
                    tick_cnt_d = tick_cnt_inc;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end

                // Burst end is judged against the burst length in force before this tick.
                if (stop_i) begin
                    leave = 1'b1;
                end else if (tick_now && (count_q != '0) && (tick_cnt_inc == count_q)) begin
                    leave  = 1'b1;
                    done_d = 1'b1;
                end

                if (pend_q && (tick_now || leave)) begin
                    period_d = pend_period_q;
                    count_d  = pend_count_q;
                    pend_d   = 1'b0;
                end

                // A word arriving on the exit edge goes straight in so nothing is stranded in IDLE.
                if (cfg_acc) begin
                    if (leave) begin
                        period_d = cfg.cfg_period_i;
                        count_d  = cfg.cfg_count_i;
                    end else begin
                        pend_d        = 1'b1;
                        pend_period_d = cfg.cfg_period_i;
                        pend_count_d  = cfg.cfg_count_i;
                    end
                end

                if (leave) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            period_q      <= '0;
            count_q       <= '0;
            cnt_q         <= '0;
            tick_q        <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            tick_cnt_q    <= '0;
            pend_q        <= 1'b0;
            pend_period_q <= '0;
            pend_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            period_q      <= period_d;
            count_q       <= count_d;
            cnt_q         <= cnt_d;
            tick_q        <= tick_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            tick_cnt_q    <= tick_cnt_d;
            pend_q        <= pend_d;
            pend_period_q <= pend_period_d;
            pend_count_q  <= pend_count_d;
        end
    end

    assign tick_o     = tick_q;
    assign done_o     = done_q;
    assign busy_o     = busy_q;
    assign tick_cnt_o = tick_cnt_q;

endmodule

// File: tb/tb_prescaler_ctrl.sv
// Bench for prescaler_ctrl: a tick-schedule model (absolute cycle of next tick)
// checked every cycle, plus directed scenarios with hand-computed timings.
module tb_prescaler_ctrl;
    localparam int CNT_W   = 16;
    localparam int BURST_W = 8;

    logic               clk_i   = 1'b0;
    logic               rst_i   = 1'b1;
    logic               start_i = 1'b0;
    logic               stop_i  = 1'b0;
    logic               tick_o, done_o, busy_o;
    logic [BURST_W-1:0] tick_cnt_o;

    prescaler_ctrl_if #(.CNT_W(CNT_W), .BURST_W(BURST_W)) cfg_if ();

    prescaler_ctrl #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cfg        (cfg_if),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .tick_o     (tick_o),
        .done_o     (done_o),
        .busy_o     (busy_o),
        .tick_cnt_o (tick_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Model: run flag, config in force, pending word, absolute cycle of the next tick.
    longint cyc = 0;
    bit     m_run = 0;
    int     m_period = 0, m_count = 0, m_ticks = 0;
    bit     m_pend = 0;
    int     p_period = 0, p_count = 0;
    longint m_next = 0;
    bit     e_tick = 0, e_done = 0;

    longint tick_log[$];
    int     done_cnt = 0;
    longint done_cyc = 0;

    function automatic void model_reset();
        m_run = 0; m_period = 0; m_count = 0; m_ticks = 0;
        m_pend = 0; p_period = 0; p_count = 0;
        e_tick = 0; e_done = 0;
    endfunction

    function automatic void model_step();
        bit acc, is_tick, leaving;
        acc = cfg_if.cfg_valid_i && !m_pend;
        e_tick = 0;
        e_done = 0;
        if (!m_run) begin
            if (acc) begin
                m_period = int'(cfg_if.cfg_period_i);
                m_count  = int'(cfg_if.cfg_count_i);
            end
            if (start_i) begin
                m_run   = 1;
                m_ticks = 0;
                m_next  = cyc + m_period + 1;
            end
        end else begin
            is_tick = (cyc == m_next);
            leaving = stop_i;
            if (is_tick) begin
                e_tick  = 1;
                m_ticks = (m_ticks + 1) % 256;
                if (!stop_i && m_count != 0 && m_ticks == m_count) begin
                    e_done  = 1;
                    leaving = 1;
                end
            end
            if (m_pend && (is_tick || leaving)) begin
                m_period = p_period;
                m_count  = p_count;
                m_pend   = 0;
            end
            if (is_tick) m_next = cyc + m_period + 1;
            if (acc) begin
                if (leaving) begin
                    m_period = int'(cfg_if.cfg_period_i);
                    m_count  = int'(cfg_if.cfg_count_i);
                end else begin
                    m_pend   = 1;
                    p_period = int'(cfg_if.cfg_period_i);
                    p_count  = int'(cfg_if.cfg_count_i);
                end
            end
            if (leaving) m_run = 0;
        end
    endfunction

    always @(posedge clk_i) begin
        cyc++;
        if (rst_i) model_reset();
        else       model_step();
        #1;
        if (tick_o === 1'b1) tick_log.push_back(cyc);
        if (done_o === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        chk("tick_o",      tick_o,      e_tick);
        chk("done_o",      done_o,      e_done);
        chk("busy_o",      busy_o,      m_run);
        chk("tick_cnt_o",  tick_cnt_o,  m_ticks);
        chk("cfg_ready_o", cfg_if.cfg_ready_o, !m_pend);
    end

    task automatic drive_cfg(input int p, input int n);
        cfg_if.cfg_valid_i  = 1'b1;
        cfg_if.cfg_period_i = CNT_W'(p);
        cfg_if.cfg_count_i  = BURST_W'(n);
    endtask

    task automatic stop_run();
        stop_i = 1'b1;
        @(negedge clk_i);
        stop_i = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint k;
        cfg_if.cfg_valid_i  = 1'b0;
        cfg_if.cfg_period_i = '0;
        cfg_if.cfg_count_i  = '0;

        #1;
        chk("rst_tick",  tick_o, 0);
        chk("rst_done",  done_o, 0);
        chk("rst_busy",  busy_o, 0);
        chk("rst_cnt",   tick_cnt_o, 0);
        chk("rst_ready", cfg_if.cfg_ready_o, 1);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        // 1: continuous P=3
        drive_cfg(3, 0); start_i = 1'b1;
        @(negedge clk_i); k = cyc;
        cfg_if.cfg_valid_i = 1'b0; start_i = 1'b0; tick_log.delete();
        repeat (12) @(negedge clk_i);
        chk("t1_nticks", tick_log.size(), 3);
        chk("t1_first",  tick_log[0] - k, 4);
        chk("t1_gap",    tick_log[2] - tick_log[1], 4);
        chk("t1_busy",   busy_o, 1);
        chk("t1_cnt",    tick_cnt_o, 3);
        stop_run();

        // 2: burst P=1 N=5
        drive_cfg(1, 5); start_i = 1'b1;
        @(negedge clk_i); k = cyc;
        cfg_if.cfg_valid_i = 1'b0; start_i = 1'b0; tick_log.delete(); done_cnt = 0;
        repeat (14) @(negedge clk_i);
        chk("t2_nticks",  tick_log.size(), 5);
        chk("t2_first",   tick_log[0] - k, 2);
        chk("t2_gap",     tick_log[4] - tick_log[3], 2);
        chk("t2_done",    done_cnt, 1);
        chk("t2_done_at", done_cyc - k, 10);
        chk("t2_busy",    busy_o, 0);
        chk("t2_cnt",     tick_cnt_o, 5);

        // 3: P=7 running, P=1 written mid-period
        drive_cfg(7, 0); start_i = 1'b1;
        @(negedge clk_i); k = cyc;
        cfg_if.cfg_valid_i = 1'b0; start_i = 1'b0; tick_log.delete();
        repeat (10) @(negedge clk_i);
        drive_cfg(1, 0);
        @(negedge clk_i);
        cfg_if.cfg_valid_i = 1'b0;
        chk("t3_ready_lo", cfg_if.cfg_ready_o, 0);
        repeat (11) @(negedge clk_i);
        chk("t3_nticks", tick_log.size(), 5);
        chk("t3_gap_old", tick_log[1] - tick_log[0], 8);
        chk("t3_gap_new", tick_log[2] - tick_log[1], 2);
        chk("t3_gap_new2", tick_log[3] - tick_log[2], 2);
        chk("t3_ready_hi", cfg_if.cfg_ready_o, 1);
        stop_run();

        // 4: P=0 continuous, then stop
        drive_cfg(0, 0); start_i = 1'b1;
        @(negedge clk_i);
        cfg_if.cfg_valid_i = 1'b0; start_i = 1'b0; tick_log.delete(); done_cnt = 0;
        repeat (5) @(negedge clk_i);
        chk("t4_nticks", tick_log.size(), 5);
        stop_i = 1'b1;
        @(negedge clk_i);
        stop_i = 1'b0;
        chk("t4_stop_tick", tick_o, 1);
        chk("t4_stop_busy", busy_o, 0);
        @(negedge clk_i);
        chk("t4_after_tick", tick_o, 0);
        chk("t4_no_done", done_cnt, 0);

        // 5: stop on a tick edge; then start+stop together in IDLE
        drive_cfg(3, 0); start_i = 1'b1;
        @(negedge clk_i);
        cfg_if.cfg_valid_i = 1'b0; start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        stop_i = 1'b1;
        @(negedge clk_i);
        stop_i = 1'b0;
        chk("t5_stop_tick", tick_o, 1);
        chk("t5_stop_busy", busy_o, 0);
        chk("t5_stop_cnt",  tick_cnt_o, 1);
        @(negedge clk_i);
        chk("t5_after_tick", tick_o, 0);
        drive_cfg(2, 0); start_i = 1'b1; stop_i = 1'b1;
        @(negedge clk_i); k = cyc;
        cfg_if.cfg_valid_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; tick_log.delete();
        chk("t5_both_busy", busy_o, 1);
        repeat (3) @(negedge clk_i);
        chk("t5_both_nticks", tick_log.size(), 1);
        chk("t5_both_first",  tick_log[0] - k, 3);
        stop_run();

        // 6: async reset mid-run with a pending word
        drive_cfg(7, 0); start_i = 1'b1;
        @(negedge clk_i);
        cfg_if.cfg_valid_i = 1'b0; start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        drive_cfg(1, 0);
        @(negedge clk_i);
        cfg_if.cfg_valid_i = 1'b0;
        chk("t6_pend", cfg_if.cfg_ready_o, 0);
        chk("t6_pre_cnt", tick_cnt_o, 1);
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("t6_busy",  busy_o, 0);
        chk("t6_cnt",   tick_cnt_o, 0);
        chk("t6_ready", cfg_if.cfg_ready_o, 1);
        chk("t6_tick",  tick_o, 0);
        chk("t6_done",  done_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0; tick_log.delete();
        repeat (2) @(negedge clk_i);
        chk("t6_p0_nticks", tick_log.size(), 2);
        chk("t6_p0_cnt", tick_cnt_o, 2);
        stop_run();

        // 7: tick_cnt_o wraps in continuous mode
        drive_cfg(0, 0); start_i = 1'b1;
        @(negedge clk_i);
        cfg_if.cfg_valid_i = 1'b0; start_i = 1'b0;
        repeat (257) @(negedge clk_i);
        chk("t7_wrap", tick_cnt_o, 1);
        chk("t7_busy", busy_o, 1);
        stop_run();

        // 8: held start restarts 2-tick bursts
        drive_cfg(0, 2); start_i = 1'b1; done_cnt = 0;
        @(negedge clk_i);
        cfg_if.cfg_valid_i = 1'b0;
        repeat (8) @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        chk("t8_dones", done_cnt, 3);
        chk("t8_busy",  busy_o, 0);
        chk("t8_cnt",   tick_cnt_o, 2);

        repeat (2) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
